// File: rtl/cpu_run_controller_if.sv
// Run-controller handshake bundle: board/decode requests in, PC/pipeline controls and status out.
// The controller takes the slave modport. The board/decode side or the bench takes the master modport.
interface cpu_run_controller_if #(
    parameter int CNT_W = 32
);
    logic             go;
    logic             com_req;
    logic             end_req;
    logic             com_ack;
    logic             start;
    logic             stall;
    logic             com_valid;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] cycle_count;
    logic [2:0]       state;

    modport master (
        output go, com_req, end_req, com_ack,
        input  start, stall, com_valid, done, error, cycle_count, state
    );

    modport slave (
        input  go, com_req, end_req, com_ack,
        output start, stall, com_valid, done, error, cycle_count, state
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run-state sequencer: starts on go, stalls for COM valid/ack, drains on END, counts active cycles.
// All outputs are registered with 1-cycle latency. COM_WAIT stalls the pipeline until ack arrives or TIMEOUT expires.
module cpu_run_controller #(
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT      = 1023,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_run_controller_if.slave   bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RUN         = 3'd1,
        COM_WAIT    = 3'd2,
        COM_RELEASE = 3'd3,
        DRAIN       = 3'd4,
        HALT        = 3'd5,
        ERROR       = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        drain_cnt;
    logic [CNT_W-1:0]  cyc_cnt;
    logic              start_q;
    logic              stall_q;
    logic              done_q;
    logic              error_q;
    logic              active;

    assign active = (state_q == RUN) || (state_q == COM_WAIT) ||
                    (state_q == COM_RELEASE) || (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (bus.go) state_d = RUN;
            // END has priority, so a COM decoded alongside END is dropped.
            RUN: begin
                if (bus.end_req)      state_d = DRAIN;
                else if (bus.com_req) state_d = COM_WAIT;
            end
            COM_WAIT: begin
                if (bus.com_ack)                              state_d = COM_RELEASE;
                else if (wait_cnt == WAIT_W'(TIMEOUT - 1))    state_d = ERROR;
            end
            COM_RELEASE: state_d = RUN;
            DRAIN:       if (drain_cnt == 4'(DRAIN_CYCLES - 1)) state_d = HALT;
            HALT:        state_d = HALT;
            ERROR:       state_d = ERROR;
            default:     state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state, so each one matches the state register after the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            cyc_cnt   <= '0;
            start_q   <= 1'b0;
            stall_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= (state_d == RUN) || (state_d == COM_RELEASE) || (state_d == DRAIN);
            stall_q <= (state_d == COM_WAIT);
            done_q  <= (state_d == HALT);
            error_q <= (state_d == ERROR);

            if (state_q != COM_WAIT)  wait_cnt <= '0;
            else if (!bus.com_ack)    wait_cnt <= wait_cnt + 1'b1;

            if (state_q != DRAIN) drain_cnt <= '0;
            else                  drain_cnt <= drain_cnt + 1'b1;

            if (state_q == IDLE && bus.go)    cyc_cnt <= '0;
            else if (active && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    assign bus.state       = state_q;
    assign bus.start       = start_q;
    assign bus.stall       = stall_q;
    assign bus.com_valid   = stall_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.cycle_count = cyc_cnt;
endmodule
